// File: rtl/neuron_lut_pkg.sv
// Shared widths, LUT types and the round-robin pick helper
// for the folded LogicNets neuron scheduler.
package neuron_lut_pkg;

   localparam int IN_W    = 8;
   localparam int OUT_W   = 2;
   localparam int MAX_REQ = 16;
   localparam int MAX_W   = 4;

   typedef logic [IN_W-1:0]  lut_addr_t;
   typedef logic [OUT_W-1:0] lut_res_t;

   // Scan downwards so the lowest offset from ptr wins.
   function automatic int unsigned rr_pick(
      input logic [MAX_REQ-1:0] valid,
      input int unsigned        ptr,
      input int unsigned        n
   );
      int unsigned idx;
      rr_pick = ptr;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (int'(k) < int'(n)) begin
            idx = ptr + int'(k);
            if (idx >= n) idx = idx - n;
            if (valid[idx[MAX_W-1:0]]) rr_pick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/neuron_lut.sv
// Generated LogicNets neuron truth table, realised as a
// distributed-ROM case statement.
module neuron_lut
   import neuron_lut_pkg::*;
(
   input  logic [IN_W-1:0]  addr,
   output logic [OUT_W-1:0] res
);

   always_comb begin
      res = '0;
      case (addr)
         8'h20, 8'h30, 8'h70: res = 2'b01;
         default:             res = 2'b00;
      endcase
   end

endmodule

// File: rtl/neuron_lut_rr_sched.sv
// Round-robin time-multiplexer sharing one neuron LUT among
// NUM_REQ requesters through a two-stage in-order pipeline.
module neuron_lut_rr_sched
   import neuron_lut_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*IN_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [OUT_W-1:0]          rsp_data,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic                      busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] winner;
   logic [ID_W-1:0] id1;
   logic [ID_W-1:0] id2;
   lut_addr_t       addr_mux;
   lut_addr_t       addr1;
   lut_res_t        lut_out;
   lut_res_t        res2;
   logic            v1;
   logic            v2;
   logic            s2_adv;
   logic            s1_load;
   logic            accept;

   always_comb begin
      winner = ID_W'(rr_pick(MAX_REQ'(req_valid),
                             int'(ptr),
                             NUM_REQ));
      addr_mux = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) begin
            addr_mux = req_data[i*IN_W +: IN_W];
         end
      end
   end

   // rsp_ready reaches req_ready combinationally through s2_adv.
   assign s2_adv  = !v2 || rsp_ready;
   assign s1_load = !v1 || s2_adv;
   assign accept  = (|req_valid) && s1_load;

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         if (winner == ID_W'(NUM_REQ - 1)) ptr <= '0;
         else                              ptr <= winner + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         addr1 <= '0;
         id1   <= '0;
      end else if (s1_load) begin
         v1 <= accept;
         if (accept) begin
            addr1 <= addr_mux;
            id1   <= winner;
         end
      end
   end

   neuron_lut u_lut (
      .addr (addr1),
      .res  (lut_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2   <= 1'b0;
         res2 <= '0;
         id2  <= '0;
      end else if (s2_adv) begin
         v2 <= v1;
         if (v1) begin
            res2 <= lut_out;
            id2  <= id1;
         end
      end
   end

   assign rsp_valid = v2;
   assign rsp_data  = res2;
   assign rsp_id    = id2;
   assign busy      = v1 || v2;

endmodule
